// File: rtl/fix_session_top.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fix_session_top                                                  |
// | Purpose  : FIX session initiator: Logon/Heartbeat/Logout byte serialiser    |
// |            with transmit-ack tracking and received-message handling.        |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module fix_session_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         configure_i,
    input  logic         start_i,
    input  logic         end_session_i,
    input  logic         connected_i,
    input  logic [1:0]   connectType_i,
    input  logic [7:0]   reconnectInt_i,
    input  logic [15:0]  starttime_i,
    input  logic [15:0]  endtime_i,
    input  logic [5:0]   beginstring_i,
    input  logic [5:0]   defaultApplVerId_i,
    input  logic [255:0] senderCompId_i,
    input  logic [255:0] targetCompId_i,
    input  logic [15:0]  hostAddr_i,
    input  logic [7:0]   heartBeatInt_i,
    input  logic [63:0]  sizeSenderId_i,
    input  logic [63:0]  sizeTargetId_i,
    input  logic [63:0]  sizeHeartBeat_i,
    input  logic         response_received_i,
    input  logic [2:0]   packet_status_i,
    input  logic         new_message_r_i,
    input  logic [2:0]   received_msg_type_i,
    output logic         connect_o,
    output logic         send_message_o,
    output logic         disconnect_o,
    output logic         ignore_o,
    output logic [7:0]   data_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONNECT  = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_ACTIVE   = 3'd4,
        S_CLOSE    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        M_LOGON  = 2'd0,
        M_HB     = 2'd1,
        M_LOGOUT = 2'd2
    } msg_t;

    state_t         state_q;
    msg_t           msg_q;
    logic           configured_q;
    logic [1:0]     conn_type_q;
    logic [7:0]     reconnect_q;
    logic [15:0]    starttime_q;
    logic [15:0]    endtime_q;
    logic [5:0]     beginstr_q;
    logic [5:0]     applver_q;
    logic [15:0]    host_q;
    logic [255:0]   sender_q;
    logic [255:0]   target_q;
    logic [7:0]     hb_q;
    logic [63:0]    mask_s_q;
    logic [63:0]    mask_t_q;
    logic [63:0]    mask_h_q;

    // Per-frame snapshot so a mid-session configure only affects the next frame.
    logic [255:0]   snd_f_q;
    logic [255:0]   tgt_f_q;
    logic [7:0]     hb_f_q;
    logic [5:0]     ns_q;
    logic [5:0]     nt_q;
    logic           nh_q;

    logic           ack_q;
    logic [2:0]     ack_st_q;
    logic           pend_q;
    logic [2:0]     pend_type_q;
    logic [1:0]     retry_q;
    logic [1:0]     seg_q;
    logic [5:0]     pos_q;
    logic           last_q;
    logic           connect_q;
    logic           send_q;
    logic           disconnect_q;
    logic           ignore_q;
    logic [7:0]     data_q;

    logic [7:0]     byte_d;
    logic [1:0]     seg_d;
    logic [5:0]     pos_d;
    logic           last_d;
    logic [5:0]     prefix_len;
    logic [5:0]     fld_len;
    logic [5:0]     seg_len;
    logic [5:0]     fld_idx;
    logic [1:0]     last_seg;

    logic           close_req;
    logic           start_new;
    logic           resend;
    logic           to_active;
    logic           pend_take;
    logic           pend_drop;
    msg_t           new_msg;

    function automatic logic [5:0] therm_len(input logic [31:0] m);
        logic [5:0] n;
        logic       run;
        n   = 6'd0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && m[i]) n = n + 6'd1;
            else             run = 1'b0;
        end
        return n;
    endfunction

    // Segments: 0 "35=" T, 1 "49=" sender, 2 "56=" target, 3 "108=" hb; each ends in SOH.
    always_comb begin
        prefix_len = (seg_q == 2'd3) ? 6'd4 : 6'd3;
        case (seg_q)
            2'd0:    fld_len = 6'd1;
            2'd1:    fld_len = ns_q;
            2'd2:    fld_len = nt_q;
            default: fld_len = {5'd0, nh_q};
        endcase
        seg_len  = prefix_len + fld_len + 6'd1;
        fld_idx  = fld_len - 6'd1 - (pos_q - prefix_len);
        last_seg = (msg_q == M_LOGON) ? 2'd3 : 2'd2;
        byte_d   = 8'h01;
        if (pos_q < prefix_len) begin
            case ({seg_q, pos_q[1:0]})
                4'b00_00: byte_d = "3";
                4'b00_01: byte_d = "5";
                4'b01_00: byte_d = "4";
                4'b01_01: byte_d = "9";
                4'b10_00: byte_d = "5";
                4'b10_01: byte_d = "6";
                4'b11_00: byte_d = "1";
                4'b11_01: byte_d = "0";
                4'b11_10: byte_d = "8";
                default:  byte_d = "=";
            endcase
        end else if (pos_q < prefix_len + fld_len) begin
            case (seg_q)
                2'd0: begin
                    case (msg_q)
                        M_LOGON: byte_d = 8'h41;
                        M_HB:    byte_d = 8'h30;
                        default: byte_d = 8'h35;
                    endcase
                end
                2'd1:    byte_d = snd_f_q[{fld_idx[4:0], 3'b000} +: 8];
                2'd2:    byte_d = tgt_f_q[{fld_idx[4:0], 3'b000} +: 8];
                default: byte_d = hb_f_q;
            endcase
        end
        if (pos_q == seg_len - 6'd1) begin
            pos_d  = 6'd0;
            seg_d  = seg_q + 2'd1;
            last_d = (seg_q == last_seg);
        end else begin
            pos_d  = pos_q + 6'd1;
            seg_d  = seg_q;
            last_d = 1'b0;
        end
    end

    // Action decode, ordered: link loss, end request, ack, pending message.
    always_comb begin
        close_req = 1'b0;
        start_new = 1'b0;
        resend    = 1'b0;
        to_active = 1'b0;
        pend_take = 1'b0;
        pend_drop = 1'b0;
        new_msg   = M_LOGON;
        case (state_q)
            S_CONNECT: begin
                if (end_session_i)    close_req = 1'b1;
                else if (connected_i) start_new = 1'b1;
            end
            S_SEND: begin
                if (!connected_i) close_req = 1'b1;
            end
            S_WAIT_ACK: begin
                if (!connected_i) begin
                    close_req = 1'b1;
                end else if (ack_q) begin
                    if (ack_st_q == 3'b001) begin
                        if (msg_q == M_LOGOUT) close_req = 1'b1;
                        else                   to_active = 1'b1;
                    end else if (ack_st_q == 3'b010 && retry_q != 2'd3) begin
                        resend = 1'b1;      // original + three resends, fourth NACK closes
                    end else begin
                        close_req = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (!connected_i) begin
                    close_req = 1'b1;
                end else if (end_session_i) begin
                    start_new = 1'b1;
                    new_msg   = M_LOGOUT;
                end else if (pend_q) begin
                    pend_take = 1'b1;
                    case (pend_type_q)
                        3'b010, 3'b011: begin start_new = 1'b1; new_msg = M_HB;     end
                        3'b100:         begin start_new = 1'b1; new_msg = M_LOGOUT; end
                        default:        pend_drop = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            msg_q        <= M_LOGON;
            configured_q <= 1'b0;
            conn_type_q  <= 2'd0;
            reconnect_q  <= 8'd0;
            starttime_q  <= 16'd0;
            endtime_q    <= 16'd0;
            beginstr_q   <= 6'd0;
            applver_q    <= 6'd0;
            host_q       <= 16'd0;
            sender_q     <= 256'd0;
            target_q     <= 256'd0;
            hb_q         <= 8'd0;
            mask_s_q     <= 64'd0;
            mask_t_q     <= 64'd0;
            mask_h_q     <= 64'd0;
            snd_f_q      <= 256'd0;
            tgt_f_q      <= 256'd0;
            hb_f_q       <= 8'd0;
            ns_q         <= 6'd0;
            nt_q         <= 6'd0;
            nh_q         <= 1'b0;
            ack_q        <= 1'b0;
            ack_st_q     <= 3'd0;
            pend_q       <= 1'b0;
            pend_type_q  <= 3'd0;
            retry_q      <= 2'd0;
            seg_q        <= 2'd0;
            pos_q        <= 6'd0;
            last_q       <= 1'b0;
            connect_q    <= 1'b0;
            send_q       <= 1'b0;
            disconnect_q <= 1'b0;
            ignore_q     <= 1'b0;
            data_q       <= 8'h00;
        end else begin
            disconnect_q <= 1'b0;
            ignore_q     <= 1'b0;
            if (configure_i) begin
                configured_q <= 1'b1;
                conn_type_q  <= connectType_i;
                reconnect_q  <= reconnectInt_i;
                starttime_q  <= starttime_i;
                endtime_q    <= endtime_i;
                beginstr_q   <= beginstring_i;
                applver_q    <= defaultApplVerId_i;
                host_q       <= hostAddr_i;
                sender_q     <= senderCompId_i;
                target_q     <= targetCompId_i;
                hb_q         <= heartBeatInt_i;
                mask_s_q     <= sizeSenderId_i;
                mask_t_q     <= sizeTargetId_i;
                mask_h_q     <= sizeHeartBeat_i;
            end
            if ((state_q == S_SEND || state_q == S_WAIT_ACK) && response_received_i) begin
                ack_q    <= 1'b1;
                ack_st_q <= packet_status_i;
            end
            if (new_message_r_i) begin
                if (state_q == S_IDLE || pend_q) begin
                    ignore_q <= 1'b1;
                end else begin
                    pend_q      <= 1'b1;
                    pend_type_q <= received_msg_type_i;
                end
            end
            if (pend_take) pend_q   <= 1'b0;
            if (pend_drop) ignore_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start_i && configured_q) begin
                        state_q   <= S_CONNECT;
                        connect_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (last_q) begin
                        state_q <= S_WAIT_ACK;
                        send_q  <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        data_q <= byte_d;
                        seg_q  <= seg_d;
                        pos_q  <= pos_d;
                        last_q <= last_d;
                    end
                end
                S_WAIT_ACK: begin
                    if (to_active) begin
                        state_q <= S_ACTIVE;
                        ack_q   <= 1'b0;
                    end
                end
                S_CLOSE: begin
                    disconnect_q <= 1'b1;
                    ack_q        <= 1'b0;
                    pend_q       <= 1'b0;
                    retry_q      <= 2'd0;
                    last_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: ;
            endcase

            // The first byte of every frame is the constant '3', so it needs no snapshot.
            if (start_new || resend) begin
                state_q   <= S_SEND;
                connect_q <= 1'b0;
                send_q    <= 1'b1;
                data_q    <= 8'h33;
                seg_q     <= 2'd0;
                pos_q     <= 6'd1;
                last_q    <= 1'b0;
                ack_q     <= 1'b0;
            end
            if (start_new) begin
                msg_q   <= new_msg;
                retry_q <= 2'd0;
                snd_f_q <= sender_q;
                tgt_f_q <= target_q;
                hb_f_q  <= hb_q;
                ns_q    <= therm_len(mask_s_q[31:0]);
                nt_q    <= therm_len(mask_t_q[31:0]);
                nh_q    <= mask_h_q[0];
            end
            if (resend) retry_q <= retry_q + 2'd1;
            if (close_req) begin
                state_q   <= S_CLOSE;
                connect_q <= 1'b0;
                send_q    <= 1'b0;
                last_q    <= 1'b0;
            end
        end
    end

    assign connect_o      = connect_q;
    assign send_message_o = send_q;
    assign disconnect_o   = disconnect_q;
    assign ignore_o       = ignore_q;
    assign data_o         = data_q;

    logic unused_cfg;
    assign unused_cfg = ^{conn_type_q, reconnect_q, starttime_q, endtime_q, beginstr_q,
                          applver_q, host_q, mask_s_q[63:32], mask_t_q[63:32],
                          mask_h_q[63:1], fld_idx[5]};

endmodule
`default_nettype wire

// File: tb/tb_fix_session_top.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_fix_session_top                                               |
// | Purpose  : Scoreboard bench for fix_session_top: frames, acks, NACK retry.  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_fix_session_top;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         configure_i = 1'b0, start_i = 1'b0, end_session_i = 1'b0, connected_i = 1'b0;
    logic [1:0]   connectType_i = 2'd1;
    logic [7:0]   reconnectInt_i = 8'd5;
    logic [15:0]  starttime_i = 16'h0800, endtime_i = 16'h1700, hostAddr_i = 16'hC0A8;
    logic [5:0]   beginstring_i = 6'd4, defaultApplVerId_i = 6'd9;
    logic [255:0] senderCompId_i = '0, targetCompId_i = '0;
    logic [7:0]   heartBeatInt_i = 8'h00;
    logic [63:0]  sizeSenderId_i = '0, sizeTargetId_i = '0, sizeHeartBeat_i = '0;
    logic         response_received_i = 1'b0;
    logic [2:0]   packet_status_i = 3'd0;
    logic         new_message_r_i = 1'b0;
    logic [2:0]   received_msg_type_i = 3'd0;
    logic         connect_o, send_message_o, disconnect_o, ignore_o;
    logic [7:0]   data_o;

    always #5 clk = ~clk;

    fix_session_top dut (
        .clk(clk), .rst(rst),
        .configure_i(configure_i), .start_i(start_i), .end_session_i(end_session_i),
        .connected_i(connected_i), .connectType_i(connectType_i), .reconnectInt_i(reconnectInt_i),
        .starttime_i(starttime_i), .endtime_i(endtime_i), .beginstring_i(beginstring_i),
        .defaultApplVerId_i(defaultApplVerId_i), .senderCompId_i(senderCompId_i),
        .targetCompId_i(targetCompId_i), .hostAddr_i(hostAddr_i), .heartBeatInt_i(heartBeatInt_i),
        .sizeSenderId_i(sizeSenderId_i), .sizeTargetId_i(sizeTargetId_i),
        .sizeHeartBeat_i(sizeHeartBeat_i), .response_received_i(response_received_i),
        .packet_status_i(packet_status_i), .new_message_r_i(new_message_r_i),
        .received_msg_type_i(received_msg_type_i), .connect_o(connect_o),
        .send_message_o(send_message_o), .disconnect_o(disconnect_o), .ignore_o(ignore_o),
        .data_o(data_o)
    );

    localparam logic [1:0] K_BYTE = 2'd0;
    localparam logic [1:0] K_DISC = 2'd1;
    localparam logic [1:0] K_IGN  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   nbyte = 0;

    task automatic push(input logic [1:0] k, input logic [7:0] b);
        exp_t e;
        e.kind = k;
        e.b    = b;
        q.push_back(e);
    endtask

    task automatic push_field(input string s);
        for (int i = 0; i < s.len(); i++) push(K_BYTE, s[i]);
        push(K_BYTE, 8'h01);
    endtask

    task automatic push_frame(input string hdr, input bit logon);
        push_field(hdr);
        push_field("49=client");
        push_field("56=ordermatch");
        if (logon) push_field("108=1");
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic mon(input logic [1:0] k, input logic [7:0] b);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d byte=%0h want nothing", k, b);
        end else begin
            e = q.pop_front();
            if (e.kind !== k || (k == K_BYTE && e.b !== b)) begin
                bad++;
                $display("FAIL event_%0d: got kind=%0d byte=%0h want kind=%0d byte=%0h",
                         nbyte, k, b, e.kind, e.b);
            end
        end
        nbyte++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (send_message_o) mon(K_BYTE, data_o);
                if (disconnect_o)   mon(K_DISC, 8'h00);
                if (ignore_o)       mon(K_IGN, 8'h00);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pending events want 0 (timeout)", name, q.size());
            q.delete();
        end
    endtask

    task automatic wait_send(input logic v, input string name);
        int n;
        n = 0;
        while (send_message_o !== v && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (send_message_o !== v) begin
            bad++;
            $display("FAIL %s: got send_message_o=%b want %b (timeout)", name, send_message_o, v);
        end
    endtask

    task automatic msg(input logic [2:0] t);
        received_msg_type_i = t;
        new_message_r_i     = 1'b1;
        tick();
        new_message_r_i     = 1'b0;
    endtask

    task automatic resp(input logic [2:0] s);
        packet_status_i     = s;
        response_received_i = 1'b1;
        tick();
        response_received_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        ticks(2);
        check("rst_connect", connect_o, 0);
        check("rst_send", send_message_o, 0);
        check("rst_disconnect", disconnect_o, 0);
        check("rst_ignore", ignore_o, 0);
        check("rst_data", data_o, 32'h00);
        rst = 1'b1;
        ticks(2);

        // start without configuration must not connect
        pulse_start();
        check("unconfigured_connect", connect_o, 0);
        ticks(2);
        check("unconfigured_connect_late", connect_o, 0);

        push(K_IGN, 8'h00);
        msg(3'b010);
        wait_drain(10, "idle_ignore");

        senderCompId_i  = "client";
        targetCompId_i  = "ordermatch";
        heartBeatInt_i  = 8'h31;
        sizeSenderId_i  = 64'h3F;
        sizeTargetId_i  = 64'h3FF;
        sizeHeartBeat_i = 64'h1;
        configure_i = 1'b1;
        tick();
        configure_i = 1'b0;

        pulse_start();
        check("connect_after_start", connect_o, 1);
        ticks(3);
        check("connect_held", connect_o, 1);
        push_frame("35=A", 1'b1);
        connected_i = 1'b1;
        tick();
        check("connect_dropped", connect_o, 0);
        check("first_byte_valid", send_message_o, 1);
        check("first_byte", data_o, 32'h33);
        ticks(4);
        resp(3'b001);
        wait_drain(100, "logon_frame");
        ticks(3);

        for (int h = 0; h < 2; h++) begin
            push_frame("35=0", 1'b0);
            msg(3'b010);
            wait_drain(100, "heartbeat_frame");
            tick();
            resp(3'b001);
            ticks(3);
        end

        push(K_IGN, 8'h00);
        msg(3'b111);
        wait_drain(10, "active_ignore");
        ticks(2);

        push_frame("35=5", 1'b0);
        msg(3'b100);
        wait_drain(100, "logout_frame");
        tick();
        push(K_DISC, 8'h00);
        resp(3'b001);
        wait_drain(20, "logout_disconnect");
        tick();
        check("idle_after_logout_connect", connect_o, 0);
        check("idle_after_logout_send", send_message_o, 0);

        for (int r = 0; r < 4; r++) push_frame("35=A", 1'b1);
        push(K_DISC, 8'h00);
        pulse_start();
        for (int r = 0; r < 4; r++) begin
            wait_send(1'b1, "nack_frame_start");
            wait_send(1'b0, "nack_frame_end");
            resp(3'b010);
        end
        wait_drain(50, "nack_disconnect");
        ticks(3);
        check("idle_after_nack_connect", connect_o, 0);
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
